// File: rtl/char_buffer_writer.sv
// ---------------------------------------------------------------------------
// CharBufferWriter (module char_buffer_writer)
//
// Purpose:
//   Formats one text row per voltage channel into a character buffer.
//   Each row reads "CHnn d.ddd V". Rows are written only during vertical
//   blank. Channels that request an update are served one row at a time,
//   chosen round-robin.
//
// Parameters:
//   N_CH       number of voltage channels (one text row each)
//   ROW_CHARS  characters per text row
//   BASE_ADDR  char-buffer address of row 0, column 0
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   req       in   per-channel update request, level, held until granted
//   ch_bcd    in   4 BCD digits per channel, channel k at [16k+15:16k]
//   vblnk_in  in   vertical blank; writes happen only while high
//   grant     out  one-hot, one-cycle acknowledge of the served channel
//   wr_en     out  char-buffer write strobe
//   wr_addr   out  char-buffer write address
//   wr_data   out  ASCII code being written
//   busy      out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module char_buffer_writer #(
    parameter int N_CH      = 13,
    parameter int ROW_CHARS = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req,
    input  logic [16*N_CH-1:0]   ch_bcd,
    input  logic                 vblnk_in,
    output logic [N_CH-1:0]      grant,
    output logic                 wr_en,
    output logic [7:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int COL_W = (ROW_CHARS > 1) ? $clog2(ROW_CHARS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state_q;
    logic [COL_W-1:0]   col_q;
    logic [IDX_W-1:0]   rrPtr_q;
    logic [IDX_W-1:0]   idx_q;
    logic [15:0]        bcd_q;
    logic [N_CH-1:0]    grant_q;

    logic               selFound;
    logic [IDX_W-1:0]   selIdx;
    logic [N_CH-1:0]    selOneHot;
    logic [7:0]         rowChar;

    // ASCII for one BCD digit; anything above 9 is shown as '?'.
    function automatic logic [7:0] bcdChar(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    // Round-robin search: walk the request vector starting at the pointer,
    // wrapping from the top channel back to channel 0, and take the first
    // set bit. The pointer always holds a value below N_CH, so a single
    // subtraction is enough to wrap the candidate index.
    always_comb begin
        int cand;
        cand      = 0;
        selFound  = 1'b0;
        selIdx    = '0;
        selOneHot = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = int'(rrPtr_q) + i;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!selFound && req[cand]) begin
                selFound        = 1'b1;
                selIdx          = IDX_W'(cand);
                selOneHot[cand] = 1'b1;
            end
        end
    end

    // Main controller. The winning channel and its digits are captured on
    // the way into ARB, so the grant pulse is a clean registered output that
    // is high for exactly the ARB cycle. From then on the row is built only
    // from the latched copy, so later changes to req or ch_bcd cannot
    // disturb a row in progress. In WRITE the column only advances on
    // cycles where vblank is high; when vblank drops, the current column is
    // held and retried once it returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            rrPtr_q <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            grant_q <= '0;
        end else begin
            grant_q <= '0;
            case (state_q)
                IDLE: begin
                    if (vblnk_in && selFound) begin
                        state_q <= ARB;
                        idx_q   <= selIdx;
                        bcd_q   <= ch_bcd[16*selIdx +: 16];
                        grant_q <= selOneHot;
                    end
                end
                ARB: begin
                    state_q <= WRITE;
                    col_q   <= '0;
                end
                WRITE: begin
                    if (vblnk_in) begin
                        if (int'(col_q) == ROW_CHARS - 1) begin
                            col_q   <= '0;
                            state_q <= IDLE;
                            rrPtr_q <= (int'(idx_q) == N_CH - 1) ? '0 : idx_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Character for the current column of the latched row. The channel
    // label is one-based and always printed as two decimal digits.
    always_comb begin
        int chNum;
        int tens;
        int ones;
        chNum   = int'(idx_q) + 1;
        tens    = chNum / 10;
        ones    = chNum % 10;
        rowChar = 8'h20;
        case (int'(col_q))
            0:       rowChar = 8'h43;
            1:       rowChar = 8'h48;
            2:       rowChar = {4'h3, 4'(tens)};
            3:       rowChar = {4'h3, 4'(ones)};
            4:       rowChar = 8'h20;
            5:       rowChar = bcdChar(bcd_q[15:12]);
            6:       rowChar = 8'h2E;
            7:       rowChar = bcdChar(bcd_q[11:8]);
            8:       rowChar = bcdChar(bcd_q[7:4]);
            9:       rowChar = bcdChar(bcd_q[3:0]);
            10:      rowChar = 8'h20;
            11:      rowChar = 8'h56;
            default: rowChar = 8'h20;
        endcase
    end

    // Outputs come straight from registered state. Address and data stay
    // put while a write is paused by vblank; only the strobe is gated.
    // Outside WRITE everything is zero, so reset clears the outputs
    // asynchronously through the state register.
    always_comb begin
        grant   = grant_q;
        busy    = (state_q != IDLE);
        wr_en   = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        if (state_q == WRITE) begin
            wr_en   = vblnk_in;
            wr_addr = 8'(BASE_ADDR + int'(idx_q) * ROW_CHARS + int'(col_q));
            wr_data = rowChar;
        end
    end

endmodule

// File: tb/tb_char_buffer_writer.sv
// ---------------------------------------------------------------------------
// Testbench for char_buffer_writer: directed scenarios with hand-computed
// row texts and addresses. Inputs are driven and outputs sampled on the
// falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_char_buffer_writer;

    localparam int N_CH      = 13;
    localparam int ROW_CHARS = 12;

    logic                clk;
    logic                rst;
    logic [N_CH-1:0]     reqV;
    logic [16*N_CH-1:0]  chBcd;
    logic                vblnk;
    logic [N_CH-1:0]     grant;
    logic                wrEn;
    logic [7:0]          wrAddr;
    logic [7:0]          wrData;
    logic                busy;

    int checks = 0;
    int errors = 0;

    char_buffer_writer #(
        .N_CH      (N_CH),
        .ROW_CHARS (ROW_CHARS),
        .BASE_ADDR (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (reqV),
        .ch_bcd   (chBcd),
        .vblnk_in (vblnk),
        .grant    (grant),
        .wr_en    (wrEn),
        .wr_addr  (wrAddr),
        .wr_data  (wrData),
        .busy     (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runaway guard in case some wait is never satisfied
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] r, input logic vb);
        reqV  = r;
        vblnk = vb;
    endtask

    task automatic setBcd(input int ch, input logic [15:0] v);
        chBcd[16*ch +: 16] = v;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst  = 1'b1;
        reqV = '0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    // Reference row text for the round-robin sweep
    function automatic string digStr(input logic [3:0] d);
        if (d > 4'd9) return "?";
        return $sformatf("%0d", d);
    endfunction

    function automatic string rowText(input int ch, input logic [15:0] b);
        return $sformatf("CH%02d %s.%s%s%s V", ch + 1, digStr(b[15:12]),
                         digStr(b[11:8]), digStr(b[7:4]), digStr(b[3:0]));
    endfunction

    task automatic checkWrite(input int ch, input int c, input string txt);
        byte b;
        b = txt[c];
        checkOutput($sformatf("wr_en_ch%0d_col%0d", ch, c), 32'(wrEn), 32'd1);
        checkOutput($sformatf("wr_addr_ch%0d_col%0d", ch, c), 32'(wrAddr), 32'(ch * ROW_CHARS + c));
        checkOutput($sformatf("wr_data_ch%0d_col%0d", ch, c), 32'(wrData), 32'(8'(b)));
    endtask

    // Wait (bounded) for a grant, then check it names the expected channel
    task automatic waitGrant(input int ch, output int waited);
        waited = 0;
        while (grant == '0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        checkOutput($sformatf("grant_ch%0d", ch), 32'(grant), 32'd1 << ch);
        checkOutput($sformatf("busy_arb_ch%0d", ch), 32'(busy), 32'd1);
        checkOutput($sformatf("wr_en_arb_ch%0d", ch), 32'(wrEn), 32'd0);
    endtask

    task automatic expectRow(input int ch, input string txt, input bit keep,
                             input bit scramble, output int waited);
        waitGrant(ch, waited);
        if (!keep) reqV[ch] = 1'b0;
        if (scramble) chBcd[16*ch +: 16] = 16'h9999;
        for (int c = 0; c < ROW_CHARS; c++) begin
            @(negedge clk);
            checkWrite(ch, c, txt);
        end
    endtask

    initial begin
        int waited;
        rst   = 1'b1;
        reqV  = '0;
        chBcd = '0;
        vblnk = 1'b1;

        // Reset values
        @(negedge clk);
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_wr_en", 32'(wrEn), 32'd0);
        checkOutput("rst_wr_addr", 32'(wrAddr), 32'd0);
        checkOutput("rst_wr_data", 32'(wrData), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single channel 2, 3.300 V
        @(negedge clk);
        setBcd(2, 16'h3300);
        applyStimulus(13'h0004, 1'b1);
        expectRow(2, "CH03 3.300 V", 1'b0, 1'b0, waited);
        checkOutput("latency_ch2", 32'(waited), 32'd1);
        @(negedge clk);
        checkOutput("idle_after_row_busy", 32'(busy), 32'd0);
        checkOutput("idle_after_row_wr_en", 32'(wrEn), 32'd0);

        // Round-robin sweep with every request held
        applyReset();
        for (int k = 0; k < N_CH; k++)
            setBcd(k, {4'(k % 10), 4'((k + 1) % 10), 4'((k + 2) % 10), 4'((k + 3) % 10)});
        applyStimulus('1, 1'b1);
        expectRow(0, rowText(0, chBcd[15:0]), 1'b1, 1'b0, waited);
        for (int k = 1; k < N_CH; k++) begin
            expectRow(k, rowText(k, chBcd[16*k +: 16]), 1'b1, 1'b0, waited);
            checkOutput($sformatf("rr_gap_ch%0d", k), 32'(waited), 32'd2);
        end
        expectRow(0, rowText(0, chBcd[15:0]), 1'b1, 1'b0, waited);
        checkOutput("rr_wrap_gap", 32'(waited), 32'd2);
        reqV = '0;
        repeat (3) @(negedge clk);
        checkOutput("rr_done_busy", 32'(busy), 32'd0);

        // Vblank pause at column 5 of channel 12
        applyReset();
        setBcd(12, 16'h0987);
        setBcd(11, 16'h4242);
        applyStimulus(13'h1000, 1'b1);
        waitGrant(12, waited);
        reqV = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkWrite(12, c, "CH13 0.987 V");
        end
        @(negedge clk);
        vblnk = 1'b0;
        #1;
        checkOutput("pause_wr_en_0", 32'(wrEn), 32'd0);
        checkOutput("pause_wr_addr_0", 32'(wrAddr), 32'd149);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("pause_wr_en_%0d", i), 32'(wrEn), 32'd0);
            checkOutput($sformatf("pause_busy_%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("pause_wr_addr_%0d", i), 32'(wrAddr), 32'd149);
        end
        @(negedge clk);
        vblnk = 1'b1;
        #1;
        checkWrite(12, 5, "CH13 0.987 V");
        for (int c = 6; c < ROW_CHARS; c++) begin
            @(negedge clk);
            checkWrite(12, c, "CH13 0.987 V");
        end
        // Pointer wrapped to 0, so channel 11 beats channel 12
        @(negedge clk);
        applyStimulus(13'h1800, 1'b1);
        expectRow(11, "CH12 4.242 V", 1'b0, 1'b0, waited);
        expectRow(12, "CH13 0.987 V", 1'b0, 1'b0, waited);

        // Invalid digit; ch_bcd scrambled mid-row must not matter
        applyReset();
        setBcd(0, 16'h1A05);
        applyStimulus(13'h0001, 1'b1);
        expectRow(0, "CH01 1.?05 V", 1'b0, 1'b1, waited);

        // Reset in the middle of channel 4's row
        applyReset();
        setBcd(4, 16'h1234);
        setBcd(1, 16'h0500);
        applyStimulus(13'h0010, 1'b1);
        waitGrant(4, waited);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checkWrite(4, c, "CH05 1.234 V");
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_wr_en", 32'(wrEn), 32'd0);
        checkOutput("midrst_wr_addr", 32'(wrAddr), 32'd0);
        checkOutput("midrst_wr_data", 32'(wrData), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_grant", 32'(grant), 32'd0);
        reqV = 13'h0012;
        @(negedge clk);
        rst = 1'b0;
        expectRow(1, "CH02 0.500 V", 1'b0, 1'b0, waited);
        expectRow(4, "CH05 1.234 V", 1'b0, 1'b0, waited);

        // Request outside vblank waits in IDLE
        applyReset();
        setBcd(6, 16'h0250);
        applyStimulus(13'h0040, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("noblank_busy_%0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("noblank_grant_%0d", i), 32'(grant), 32'd0);
        end
        vblnk = 1'b1;
        expectRow(6, "CH07 0.250 V", 1'b0, 1'b0, waited);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
